// File: rtl/id_stage_ctrl.sv
// Decode-stage controller: decodes fetch entries, buffers them in a small FIFO and
// issues them in order, serializing CSR-unit work and halting after an exception.

package riscv_pkg;
    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_M = 2'b11
    } priv_lvl_t;

    localparam logic [31:0] ILLEGAL_INSTR  = 32'd2;
    localparam logic [31:0] BREAKPOINT     = 32'd3;
    localparam logic [31:0] ENV_CALL_UMODE = 32'd8;
    localparam logic [31:0] ENV_CALL_SMODE = 32'd9;
    localparam logic [31:0] ENV_CALL_MMODE = 32'd11;

    localparam logic [6:0] OPCODE_LOAD     = 7'h03;
    localparam logic [6:0] OPCODE_MISC_MEM = 7'h0f;
    localparam logic [6:0] OPCODE_OP_IMM   = 7'h13;
    localparam logic [6:0] OPCODE_AUIPC    = 7'h17;
    localparam logic [6:0] OPCODE_STORE    = 7'h23;
    localparam logic [6:0] OPCODE_OP       = 7'h33;
    localparam logic [6:0] OPCODE_LUI      = 7'h37;
    localparam logic [6:0] OPCODE_BRANCH   = 7'h63;
    localparam logic [6:0] OPCODE_JALR     = 7'h67;
    localparam logic [6:0] OPCODE_JAL      = 7'h6f;
    localparam logic [6:0] OPCODE_SYSTEM   = 7'h73;

    localparam logic [11:0] CSR_SATP = 12'h180;
endpackage

package tortoise_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] address;
        logic [31:0] instruction;
    } fetch_entry_t;

    typedef enum logic [2:0] {
        FU_NONE, FU_LOAD, FU_STORE, FU_ALU, FU_CTRL_FLOW, FU_CSR
    } fu_t;

    typedef enum logic [5:0] {
        OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_XOR, OP_OR, OP_AND, OP_SLL, OP_SRL, OP_SRA,
        OP_JAL, OP_JALR, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
        OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_MRET, OP_SRET, OP_DRET, OP_WFI,
        OP_FENCE, OP_FENCE_I
    } fu_op_t;

    typedef struct packed {
        logic [31:0] cause;
        logic [31:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [31:0] pc;
        fu_t         fu;
        fu_op_t      op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] result;   // immediate, CSR address or precomputed AUIPC value
        logic        use_imm;
        exception_t  ex;
    } scoreboard_entry_t;
endpackage

module id_decoder
    import riscv_pkg::*, tortoise_pkg::*;
(
    input  logic [31:0]       pc,
    input  logic [31:0]       instr,
    input  priv_lvl_t         priv_lvl,
    input  logic              debug_mode,
    input  logic              tvm,
    input  logic              tw,
    input  logic              tsr,
    output scoreboard_entry_t sbe
);
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] funct12;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        illegal, ecall, ebreak, csr_write;

    assign opcode    = instr[6:0];
    assign rd        = instr[11:7];
    assign funct3    = instr[14:12];
    assign rs1       = instr[19:15];
    assign rs2       = instr[24:20];
    assign funct7    = instr[31:25];
    assign funct12   = instr[31:20];
    assign imm_i     = {{20{instr[31]}}, instr[31:20]};
    assign imm_s     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b     = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u     = {instr[31:12], 12'b0};
    assign imm_j     = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign csr_write = (funct3[1:0] == 2'b01) || (rs1 != 5'd0);

    function automatic fu_op_t alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? OP_SUB : OP_ADD;
            3'd1:    return OP_SLL;
            3'd2:    return OP_SLT;
            3'd3:    return OP_SLTU;
            3'd4:    return OP_XOR;
            3'd5:    return alt ? OP_SRA : OP_SRL;
            3'd6:    return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

    // NOTE: every variable driven here gets a default first so no path can infer a latch.
    always_comb begin
        sbe     = '0;
        sbe.pc  = pc;
        illegal = 1'b0;
        ecall   = 1'b0;
        ebreak  = 1'b0;
        case (opcode)
            OPCODE_LUI, OPCODE_AUIPC: begin
                sbe.fu      = FU_ALU;
                sbe.op      = OP_ADD;
                sbe.rd      = rd;
                sbe.use_imm = 1'b1;
                sbe.result  = (opcode == OPCODE_LUI) ? imm_u : pc + imm_u;
            end
            OPCODE_JAL: begin
                sbe.fu     = FU_CTRL_FLOW;
                sbe.op     = OP_JAL;
                sbe.rd     = rd;
                sbe.result = imm_j;
            end
            OPCODE_JALR: begin
                sbe.fu     = FU_CTRL_FLOW;
                sbe.op     = OP_JALR;
                sbe.rs1    = rs1;
                sbe.rd     = rd;
                sbe.result = imm_i;
                illegal    = (funct3 != 3'd0);
            end
            OPCODE_BRANCH: begin
                sbe.fu     = FU_CTRL_FLOW;
                sbe.rs1    = rs1;
                sbe.rs2    = rs2;
                sbe.result = imm_b;
                case (funct3)
                    3'd0:    sbe.op = OP_BEQ;
                    3'd1:    sbe.op = OP_BNE;
                    3'd4:    sbe.op = OP_BLT;
                    3'd5:    sbe.op = OP_BGE;
                    3'd6:    sbe.op = OP_BLTU;
                    3'd7:    sbe.op = OP_BGEU;
                    default: illegal = 1'b1;
                endcase
            end
            OPCODE_LOAD: begin
                sbe.fu     = FU_LOAD;
                sbe.rs1    = rs1;
                sbe.rd     = rd;
                sbe.result = imm_i;
                case (funct3)
                    3'd0:    sbe.op = OP_LB;
                    3'd1:    sbe.op = OP_LH;
                    3'd2:    sbe.op = OP_LW;
                    3'd4:    sbe.op = OP_LBU;
                    3'd5:    sbe.op = OP_LHU;
                    default: illegal = 1'b1;
                endcase
            end
            OPCODE_STORE: begin
                sbe.fu     = FU_STORE;
                sbe.rs1    = rs1;
                sbe.rs2    = rs2;
                sbe.result = imm_s;
                case (funct3)
                    3'd0:    sbe.op = OP_SB;
                    3'd1:    sbe.op = OP_SH;
                    3'd2:    sbe.op = OP_SW;
                    default: illegal = 1'b1;
                endcase
            end
            OPCODE_OP_IMM: begin
                sbe.fu      = FU_ALU;
                sbe.op      = alu_op(funct3, (funct3 == 3'd5) && instr[30]);
                sbe.rs1     = rs1;
                sbe.rd      = rd;
                sbe.use_imm = 1'b1;
                sbe.result  = imm_i;
                illegal     = ((funct3 == 3'd1) && (funct7 != 7'd0)) ||
                              ((funct3 == 3'd5) && ({funct7[6], funct7[4:0]} != 6'd0));
            end
            OPCODE_OP: begin
                sbe.fu  = FU_ALU;
                sbe.op  = alu_op(funct3, funct7[5]);
                sbe.rs1 = rs1;
                sbe.rs2 = rs2;
                sbe.rd  = rd;
                illegal = (funct7 != 7'h00) &&
                          !((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
            end
            OPCODE_MISC_MEM: begin
                // Fences drain the pipeline, so they go through the serializing CSR path.
                sbe.fu = FU_CSR;
                case (funct3)
                    3'd0:    sbe.op = OP_FENCE;
                    3'd1:    sbe.op = OP_FENCE_I;
                    default: illegal = 1'b1;
                endcase
            end
            OPCODE_SYSTEM: begin
                sbe.fu = FU_CSR;
                if (funct3 == 3'd0) begin
                    case (funct12)
                        12'h000: ecall  = 1'b1;
                        12'h001: ebreak = 1'b1;
                        12'h302: begin sbe.op = OP_MRET; illegal = (priv_lvl != PRIV_LVL_M); end
                        12'h102: begin
                            sbe.op  = OP_SRET;
                            illegal = (priv_lvl == PRIV_LVL_U) || ((priv_lvl == PRIV_LVL_S) && tsr);
                        end
                        12'h7b2: begin sbe.op = OP_DRET; illegal = !debug_mode; end
                        12'h105: begin sbe.op = OP_WFI;  illegal = tw && (priv_lvl != PRIV_LVL_M); end
                        default: illegal = 1'b1;
                    endcase
                    if ((rs1 != 5'd0) || (rd != 5'd0)) illegal = 1'b1;
                end else if (funct3 == 3'd4) begin
                    illegal = 1'b1;
                end else begin
                    case (funct3[1:0])
                        2'b01:   sbe.op = OP_CSRRW;
                        2'b10:   sbe.op = OP_CSRRS;
                        default: sbe.op = OP_CSRRC;
                    endcase
                    sbe.rs1     = rs1;
                    sbe.rd      = rd;
                    sbe.use_imm = funct3[2];
                    sbe.result  = {20'b0, funct12};
                    if ((funct12[9:8] > 2'(priv_lvl)) ||
                        (csr_write && (funct12[11:10] == 2'b11)) ||
                        ((funct12 == CSR_SATP) && tvm && (priv_lvl == PRIV_LVL_S)))
                        illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            sbe.ex = '{cause: ILLEGAL_INSTR, tval: instr, valid: 1'b1};
        end else if (ecall) begin
            sbe.ex.valid = 1'b1;
            case (priv_lvl)
                PRIV_LVL_U: sbe.ex.cause = ENV_CALL_UMODE;
                PRIV_LVL_S: sbe.ex.cause = ENV_CALL_SMODE;
                default:    sbe.ex.cause = ENV_CALL_MMODE;
            endcase
        end else if (ebreak) begin
            sbe.ex = '{cause: BREAKPOINT, tval: pc, valid: 1'b1};
        end
    end
endmodule

module id_stage_ctrl
    import tortoise_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  fetch_entry_t          fetch_i,
    output logic                  fetch_ready_o,
    input  riscv_pkg::priv_lvl_t  priv_lvl_i,
    input  logic                  debug_mode_i,
    input  logic                  tvm_i,
    input  logic                  tw_i,
    input  logic                  tsr_i,
    output scoreboard_entry_t     sbe_o,
    output logic                  issue_valid_o,
    input  logic                  issue_ready_i,
    input  logic                  sb_empty_i,
    output logic                  serial_wait_o
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {RUN, WAIT_EMPTY, HALT_EX} state_t;

    state_t            state_q, state_d;
    scoreboard_entry_t mem [DEPTH];
    scoreboard_entry_t decoded, head;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              push, pop, serializing;

    id_decoder u_decoder (
        .pc         (fetch_i.address),
        .instr      (fetch_i.instruction),
        .priv_lvl   (priv_lvl_i),
        .debug_mode (debug_mode_i),
        .tvm        (tvm_i),
        .tw         (tw_i),
        .tsr        (tsr_i),
        .sbe        (decoded)
    );

    assign head          = mem[rd_ptr];
    assign sbe_o         = head;
    assign issue_valid_o = (count != '0) && (state_q == RUN);
    assign fetch_ready_o = (count < CNT_W'(DEPTH)) && (state_q != HALT_EX);
    assign serial_wait_o = (state_q == WAIT_EMPTY);
    assign push          = fetch_i.valid && fetch_ready_o && !flush_i;
    assign pop           = issue_valid_o && issue_ready_i;
    assign serializing   = (head.fu == FU_CSR) && !head.ex.valid;

    // NOTE: the entry storage is reset too, because sbe_o must read all-zero out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (flush_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update on the same edge snapshot.
            if (push) begin
                mem[wr_ptr] <= decoded;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (pop && head.ex.valid) state_d = HALT_EX;
                    else if (pop && serializing) state_d = WAIT_EMPTY;
                end
                WAIT_EMPTY: if (sb_empty_i) state_d = RUN;
                default: state_d = HALT_EX;
            endcase
        end
    end
endmodule

// File: tb/tb_id_stage_ctrl.sv
// Directed self-checking bench for id_stage_ctrl: ordering, backpressure, CSR
// serialization, exception halt, flush and reset.

module tb_id_stage_ctrl;
    import riscv_pkg::*;
    import tortoise_pkg::*;

    localparam logic [31:0] ADDI  = 32'h00100093;
    localparam logic [31:0] CSRRW = 32'h34011073;
    localparam logic [31:0] ADD   = 32'h002081B3;
    localparam logic [31:0] LUI   = 32'h123452B7;
    localparam logic [31:0] ILL   = 32'h00000000;

    logic              clk_i = 1'b0;
    logic              rst_i, flush_i;
    fetch_entry_t      fetch_i;
    logic              fetch_ready_o;
    priv_lvl_t         priv_lvl_i;
    logic              debug_mode_i, tvm_i, tw_i, tsr_i;
    scoreboard_entry_t sbe_o;
    logic              issue_valid_o, issue_ready_i, sb_empty_i, serial_wait_o;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk_i = ~clk_i;

    id_stage_ctrl #(.DEPTH(2)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .fetch_i       (fetch_i),
        .fetch_ready_o (fetch_ready_o),
        .priv_lvl_i    (priv_lvl_i),
        .debug_mode_i  (debug_mode_i),
        .tvm_i         (tvm_i),
        .tw_i          (tw_i),
        .tsr_i         (tsr_i),
        .sbe_o         (sbe_o),
        .issue_valid_o (issue_valid_o),
        .issue_ready_i (issue_ready_i),
        .sb_empty_i    (sb_empty_i),
        .serial_wait_o (serial_wait_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        fetch_i.valid       = v;
        fetch_i.instruction = instr;
        fetch_i.address     = pc;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; drive(1'b0, 32'h0, 32'h0);
        priv_lvl_i = PRIV_LVL_M; debug_mode_i = 1'b0; tvm_i = 1'b0; tw_i = 1'b0; tsr_i = 1'b0;
        issue_ready_i = 1'b0; sb_empty_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        check("rst_issue_valid", issue_valid_o, 0);
        check("rst_fetch_ready", fetch_ready_o, 1);
        check("rst_serial_wait", serial_wait_o, 0);
        check("rst_sbe_zero", 64'(sbe_o === '0), 1);

        // Back-to-back ADDI with the scoreboard always ready
        issue_ready_i = 1'b1;
        drive(1'b1, ADDI, 32'h100);
        check("b2b_idle_valid", issue_valid_o, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("b2b_valid_%0d", i), issue_valid_o, 1);
            check($sformatf("b2b_pc_%0d", i), sbe_o.pc, 32'h100 + 32'(4 * i));
            check($sformatf("b2b_ready_%0d", i), fetch_ready_o, 1);
            if (i == 0) begin
                check("addi_fu", sbe_o.fu, FU_ALU);
                check("addi_op", sbe_o.op, OP_ADD);
                check("addi_rd", sbe_o.rd, 1);
                check("addi_imm", sbe_o.result, 1);
                check("addi_use_imm", sbe_o.use_imm, 1);
            end
            if (i < 3) drive(1'b1, ADDI, 32'h100 + 32'(4 * (i + 1)));
            else       drive(1'b0, ADDI, 32'h0);
        end
        tick();
        check("b2b_drained", issue_valid_o, 0);

        // Backpressure: three requests, only two fit
        issue_ready_i = 1'b0;
        drive(1'b1, ADDI, 32'h200);
        tick();
        check("bp_ready_1", fetch_ready_o, 1);
        check("bp_pc_1", sbe_o.pc, 32'h200);
        drive(1'b1, ADDI, 32'h204);
        tick();
        check("bp_full_ready", fetch_ready_o, 0);
        drive(1'b1, ADDI, 32'h208);
        tick();
        check("bp_hold_ready", fetch_ready_o, 0);
        check("bp_hold_pc", sbe_o.pc, 32'h200);
        check("bp_hold_valid", issue_valid_o, 1);
        issue_ready_i = 1'b1;
        tick();
        check("bp_pop1_pc", sbe_o.pc, 32'h204);
        check("bp_pop1_ready", fetch_ready_o, 1);
        tick();
        check("bp_pop2_pc", sbe_o.pc, 32'h208);
        check("bp_pop2_valid", issue_valid_o, 1);
        drive(1'b0, ADDI, 32'h0);
        tick();
        check("bp_drained", issue_valid_o, 0);

        // CSR serialization, scoreboard busy for 4 cycles after the CSR issue
        drive(1'b1, CSRRW, 32'h300);
        tick();
        check("csr_valid", issue_valid_o, 1);
        check("csr_fu", sbe_o.fu, FU_CSR);
        check("csr_op", sbe_o.op, OP_CSRRW);
        check("csr_addr", sbe_o.result, 32'h340);
        check("csr_no_ex", sbe_o.ex.valid, 0);
        drive(1'b1, ADD, 32'h304);
        sb_empty_i = 1'b0;
        tick();
        drive(1'b0, ADD, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("csr_wait_%0d", i), serial_wait_o, 1);
            check($sformatf("csr_stall_%0d", i), issue_valid_o, 0);
            if (i < 3) tick();
        end
        sb_empty_i = 1'b1;
        tick();
        check("csr_resume_wait", serial_wait_o, 0);
        check("csr_resume_valid", issue_valid_o, 1);
        check("add_pc", sbe_o.pc, 32'h304);
        check("add_op", sbe_o.op, OP_ADD);
        check("add_regs", {sbe_o.rd, sbe_o.rs1, sbe_o.rs2}, {5'd3, 5'd1, 5'd2});
        tick();
        check("csr_drained", issue_valid_o, 0);

        // Illegal instruction halts issue until a flush
        drive(1'b1, ILL, 32'h400);
        tick();
        check("ill_valid", issue_valid_o, 1);
        check("ill_ex", sbe_o.ex.valid, 1);
        check("ill_cause", sbe_o.ex.cause, ILLEGAL_INSTR);
        check("ill_tval", sbe_o.ex.tval, 0);
        drive(1'b1, ADDI, 32'h404);
        tick();
        for (int i = 0; i < 10; i++) begin
            check($sformatf("halt_ready_%0d", i), fetch_ready_o, 0);
            check($sformatf("halt_valid_%0d", i), issue_valid_o, 0);
            tick();
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        drive(1'b0, ADDI, 32'h0);
        check("halt_flush_ready", fetch_ready_o, 1);
        check("halt_flush_valid", issue_valid_o, 0);

        // Flush while full and waiting on the scoreboard
        sb_empty_i = 1'b0;
        drive(1'b1, CSRRW, 32'h500);
        tick();
        check("fl_csr_valid", issue_valid_o, 1);
        drive(1'b1, ADDI, 32'h504);
        tick();
        check("fl_wait", serial_wait_o, 1);
        drive(1'b1, ADDI, 32'h508);
        tick();
        check("fl_full_ready", fetch_ready_o, 0);
        check("fl_full_valid", issue_valid_o, 0);
        drive(1'b1, ADDI, 32'h50C);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        drive(1'b0, ADDI, 32'h0);
        check("fl_valid", issue_valid_o, 0);
        check("fl_wait_clear", serial_wait_o, 0);
        check("fl_ready", fetch_ready_o, 1);
        tick();
        check("fl_empty", issue_valid_o, 0);
        drive(1'b1, ADDI, 32'h510);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        drive(1'b0, ADDI, 32'h0);
        check("fl_push_blocked", issue_valid_o, 0);
        sb_empty_i = 1'b1;

        // Reset during HALT_EX, then normal LUI issue
        issue_ready_i = 1'b0;
        priv_lvl_i = PRIV_LVL_U;
        drive(1'b1, CSRRW, 32'h600);
        tick();
        priv_lvl_i = PRIV_LVL_M;
        check("upriv_csr_ex", sbe_o.ex.valid, 1);
        check("upriv_csr_cause", sbe_o.ex.cause, ILLEGAL_INSTR);
        check("upriv_csr_tval", sbe_o.ex.tval, CSRRW);
        drive(1'b1, ADDI, 32'h604);
        tick();
        check("rs_full_ready", fetch_ready_o, 0);
        issue_ready_i = 1'b1;
        drive(1'b0, ADDI, 32'h0);
        tick();
        check("rs_halt_ready", fetch_ready_o, 0);
        check("rs_halt_valid", issue_valid_o, 0);
        check("rs_halt_pc", sbe_o.pc, 32'h604);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rs_issue_valid", issue_valid_o, 0);
        check("rs_fetch_ready", fetch_ready_o, 1);
        check("rs_serial_wait", serial_wait_o, 0);
        check("rs_sbe_zero", 64'(sbe_o === '0), 1);
        drive(1'b1, LUI, 32'h700);
        tick();
        drive(1'b0, LUI, 32'h0);
        check("lui_valid", issue_valid_o, 1);
        check("lui_pc", sbe_o.pc, 32'h700);
        check("lui_rd", sbe_o.rd, 5);
        check("lui_imm", sbe_o.result, 32'h12345000);
        tick();
        check("lui_drained", issue_valid_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
